// File: rtl/n1_ips_agu_ctrl.sv
// Intermediate parameter stack controller: sequences push, pull and clear requests onto the DSP AGU and a synchronous stack RAM.
// Optional: define N1_IPS_BOUNDS_CHECK_EN to reject push-when-full / pull-when-empty instead of wrapping SP.
module n1_ips_agu_ctrl #(
   parameter int SP_WIDTH = 12
) (
   input  logic                clk_i,
   input  logic                async_rst_i,
   input  logic                sync_rst_i,
   input  logic                us_ips_psh_i,
   input  logic                us_ips_pul_i,
   input  logic                us_ips_rst_i,
   input  logic [15:0]         us_ips_psh_data_i,
   output logic                us_ips_ack_o,
   output logic [15:0]         us_ips_pul_data_o,
   output logic                us_ips_empty_o,
   output logic                us_ips_full_o,
   output logic                us_ips_err_o,
   output logic                ips_dsp_psh_o,
   output logic                ips_dsp_pul_o,
   output logic                ips_dsp_rst_o,
   input  logic [SP_WIDTH-1:0] ips_dsp_sp_i,
   output logic [SP_WIDTH-1:0] ips_ram_adr_o,
   output logic [15:0]         ips_ram_wdata_o,
   output logic                ips_ram_we_o,
   output logic                ips_ram_re_o,
   input  logic [15:0]         ips_ram_rdata_i
);

   typedef enum logic [1:0] {IDLE, READ, CLEAR} state_t;

   state_t      state_q, state_d;
   logic        err_q, err_d;
   logic [15:0] pul_data_q, pul_data_d;
   logic        psh_blk, pul_blk;

   assign us_ips_empty_o = (ips_dsp_sp_i == '0);
   assign us_ips_full_o  = (ips_dsp_sp_i == SP_WIDTH'(1));

`ifdef N1_IPS_BOUNDS_CHECK_EN
   assign psh_blk = us_ips_full_o;
   assign pul_blk = us_ips_empty_o;
`else
   assign psh_blk = 1'b0;
   assign pul_blk = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      err_d           = err_q;
      pul_data_d      = pul_data_q;
      us_ips_ack_o    = 1'b0;
      ips_dsp_psh_o   = 1'b0;
      ips_dsp_pul_o   = 1'b0;
      ips_dsp_rst_o   = 1'b0;
      ips_ram_adr_o   = '0;
      ips_ram_wdata_o = '0;
      ips_ram_we_o    = 1'b0;
      ips_ram_re_o    = 1'b0;
      // Either reset silences every strobe so no RAM/AGU side effect races the reset.
      if (async_rst_i || sync_rst_i) begin
         state_d    = IDLE;
         err_d      = 1'b0;
         pul_data_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (us_ips_rst_i) begin
                  state_d = CLEAR;
               end else if (us_ips_psh_i && us_ips_pul_i) begin
                  us_ips_ack_o = 1'b1;
                  err_d        = 1'b1;
               end else if (us_ips_psh_i) begin
                  us_ips_ack_o = 1'b1;
                  if (psh_blk) begin
                     err_d = 1'b1;
                  end else begin
                     ips_ram_we_o    = 1'b1;
                     ips_ram_adr_o   = ips_dsp_sp_i - SP_WIDTH'(1);
                     ips_ram_wdata_o = us_ips_psh_data_i;
                     ips_dsp_psh_o   = 1'b1;
                  end
               end else if (us_ips_pul_i) begin
                  if (pul_blk) begin
                     us_ips_ack_o = 1'b1;
                     err_d        = 1'b1;
                     pul_data_d   = '0;
                  end else begin
                     ips_ram_re_o  = 1'b1;
                     ips_ram_adr_o = ips_dsp_sp_i;
                     ips_dsp_pul_o = 1'b1;
                     state_d       = READ;
                  end
               end
            end
            READ: begin
               us_ips_ack_o = 1'b1;
               pul_data_d   = ips_ram_rdata_i;
               state_d      = IDLE;
            end
            CLEAR: begin
               ips_dsp_rst_o = 1'b1;
               us_ips_ack_o  = 1'b1;
               err_d         = 1'b0;
               state_d       = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pulled data is presented in the ack cycle itself and held afterwards.
   assign us_ips_pul_data_o = pul_data_d;
   assign us_ips_err_o      = err_q;

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         state_q    <= IDLE;
         err_q      <= 1'b0;
         pul_data_q <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         pul_data_q <= pul_data_d;
      end
   end

endmodule

// File: tb/tb_n1_ips_agu_ctrl.sv
// Bench for n1_ips_agu_ctrl: models the DSP AGU and stack RAM, checks directed cases and a random push/pull/clear mix against a queue model.
module tb_n1_ips_agu_ctrl;

   logic        clk_i = 1'b0;
   logic        async_rst_i = 1'b1;
   logic        sync_rst_i = 1'b0;
   logic        us_ips_psh_i = 1'b0;
   logic        us_ips_pul_i = 1'b0;
   logic        us_ips_rst_i = 1'b0;
   logic [15:0] us_ips_psh_data_i = '0;
   logic        us_ips_ack_o;
   logic [15:0] us_ips_pul_data_o;
   logic        us_ips_empty_o, us_ips_full_o, us_ips_err_o;
   logic        ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o;
   logic [11:0] agu_sp = '0;
   logic [11:0] ips_ram_adr_o;
   logic [15:0] ips_ram_wdata_o;
   logic        ips_ram_we_o, ips_ram_re_o;
   logic [15:0] ips_ram_rdata_i = '0;

   logic        sp_load = 1'b0;
   logic [11:0] sp_load_val = '0;
   logic [15:0] mem [0:4095];

   int checks = 0;
   int failures = 0;

   n1_ips_agu_ctrl #(.SP_WIDTH(12)) dut (
      .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
      .us_ips_psh_i(us_ips_psh_i), .us_ips_pul_i(us_ips_pul_i), .us_ips_rst_i(us_ips_rst_i),
      .us_ips_psh_data_i(us_ips_psh_data_i), .us_ips_ack_o(us_ips_ack_o),
      .us_ips_pul_data_o(us_ips_pul_data_o), .us_ips_empty_o(us_ips_empty_o),
      .us_ips_full_o(us_ips_full_o), .us_ips_err_o(us_ips_err_o),
      .ips_dsp_psh_o(ips_dsp_psh_o), .ips_dsp_pul_o(ips_dsp_pul_o), .ips_dsp_rst_o(ips_dsp_rst_o),
      .ips_dsp_sp_i(agu_sp), .ips_ram_adr_o(ips_ram_adr_o), .ips_ram_wdata_o(ips_ram_wdata_o),
      .ips_ram_we_o(ips_ram_we_o), .ips_ram_re_o(ips_ram_re_o), .ips_ram_rdata_i(ips_ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // DSP AGU: own reset domain, so the controller reset never touches SP.
   always @(posedge clk_i) begin
      if (sp_load)            agu_sp <= sp_load_val;
      else if (ips_dsp_rst_o) agu_sp <= '0;
      else if (ips_dsp_psh_o) agu_sp <= agu_sp - 12'd1;
      else if (ips_dsp_pul_o) agu_sp <= agu_sp + 12'd1;
   end

   always @(posedge clk_i) begin
      if (ips_ram_we_o) mem[ips_ram_adr_o] <= ips_ram_wdata_o;
      if (ips_ram_re_o) ips_ram_rdata_i <= mem[ips_ram_adr_o];
   end

   task automatic set_sp(input logic [11:0] v);
      sp_load = 1'b1; sp_load_val = v;
      @(posedge clk_i); #1 sp_load = 1'b0;
   endtask

   task automatic test_reset();
      us_ips_psh_i = 1'b1; us_ips_psh_data_i = 16'hAAAA;
      async_rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({us_ips_ack_o, us_ips_err_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o} !== 7'b0)
         begin failures++; $display("FAIL reset_strobes got=%b exp=0000000", {us_ips_ack_o, us_ips_err_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o}); end
      checks++;
      if (us_ips_pul_data_o !== 16'h0 || ips_ram_adr_o !== 12'h0)
         begin failures++; $display("FAIL reset_data got data=%h adr=%h exp 0/0", us_ips_pul_data_o, ips_ram_adr_o); end
      us_ips_psh_i = 1'b0;
      @(posedge clk_i); #1 async_rst_i = 1'b0;
   endtask

   task automatic test_push_basic();
      set_sp(12'h000);
      us_ips_psh_i = 1'b1; us_ips_psh_data_i = 16'h1234;
      @(negedge clk_i);
      checks++;
      if ({us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o, ips_dsp_pul_o} !== 4'b1110)
         begin failures++; $display("FAIL push_strobes got=%b exp=1110", {us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o, ips_dsp_pul_o}); end
      checks++;
      if (ips_ram_adr_o !== 12'hFFF || ips_ram_wdata_o !== 16'h1234)
         begin failures++; $display("FAIL push_adr got adr=%h wdata=%h exp fff/1234", ips_ram_adr_o, ips_ram_wdata_o); end
      @(posedge clk_i); #1 us_ips_psh_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (agu_sp !== 12'hFFF || us_ips_empty_o !== 1'b0)
         begin failures++; $display("FAIL push_sp got sp=%h empty=%b exp fff/0", agu_sp, us_ips_empty_o); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_pull_basic();
      us_ips_pul_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({us_ips_ack_o, ips_ram_re_o, ips_dsp_pul_o, ips_ram_adr_o} !== {3'b011, 12'hFFF})
         begin failures++; $display("FAIL pull_issue got ack=%b re=%b pul=%b adr=%h exp 0/1/1/fff", us_ips_ack_o, ips_ram_re_o, ips_dsp_pul_o, ips_ram_adr_o); end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checks++;
      if (us_ips_ack_o !== 1'b1 || us_ips_pul_data_o !== 16'h1234)
         begin failures++; $display("FAIL pull_ack got ack=%b data=%h exp 1/1234", us_ips_ack_o, us_ips_pul_data_o); end
      @(posedge clk_i); #1 us_ips_pul_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (us_ips_ack_o !== 1'b0 || us_ips_pul_data_o !== 16'h1234 || agu_sp !== 12'h000 || us_ips_empty_o !== 1'b1)
         begin failures++; $display("FAIL pull_hold got ack=%b data=%h sp=%h empty=%b exp 0/1234/000/1", us_ips_ack_o, us_ips_pul_data_o, agu_sp, us_ips_empty_o); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_clear();
      us_ips_rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (us_ips_ack_o !== 1'b0 || ips_dsp_rst_o !== 1'b0)
         begin failures++; $display("FAIL clear_first got ack=%b rst=%b exp 0/0", us_ips_ack_o, ips_dsp_rst_o); end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checks++;
      if ({ips_dsp_rst_o, us_ips_ack_o, ips_dsp_psh_o, ips_dsp_pul_o} !== 4'b1100)
         begin failures++; $display("FAIL clear_pulse got=%b exp=1100", {ips_dsp_rst_o, us_ips_ack_o, ips_dsp_psh_o, ips_dsp_pul_o}); end
      @(posedge clk_i); #1 us_ips_rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (us_ips_err_o !== 1'b0 || agu_sp !== 12'h000 || ips_dsp_rst_o !== 1'b0)
         begin failures++; $display("FAIL clear_after got err=%b sp=%h rst=%b exp 0/000/0", us_ips_err_o, agu_sp, ips_dsp_rst_o); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_bounds();
      set_sp(12'h001);
      checks++;
      if (us_ips_full_o !== 1'b1 || us_ips_empty_o !== 1'b0)
         begin failures++; $display("FAIL full_flag got full=%b empty=%b exp 1/0", us_ips_full_o, us_ips_empty_o); end
      us_ips_psh_i = 1'b1; us_ips_psh_data_i = 16'hBEEF;
      @(negedge clk_i);
      checks++;
`ifdef N1_IPS_BOUNDS_CHECK_EN
      if ({us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o} !== 3'b100)
         begin failures++; $display("FAIL push_full got ack/we/psh=%b exp 100", {us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o}); end
`else
      if ({us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o} !== 3'b111 || ips_ram_adr_o !== 12'h000)
         begin failures++; $display("FAIL push_full got ack/we/psh=%b adr=%h exp 111/000", {us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o}, ips_ram_adr_o); end
`endif
      @(posedge clk_i); #1 us_ips_psh_i = 1'b0;
      @(negedge clk_i);
      checks++;
`ifdef N1_IPS_BOUNDS_CHECK_EN
      if (us_ips_err_o !== 1'b1 || agu_sp !== 12'h001)
         begin failures++; $display("FAIL push_full_after got err=%b sp=%h exp 1/001", us_ips_err_o, agu_sp); end
      @(posedge clk_i); #1;
      test_clear();
`else
      if (us_ips_err_o !== 1'b0 || agu_sp !== 12'h000)
         begin failures++; $display("FAIL push_full_after got err=%b sp=%h exp 0/000", us_ips_err_o, agu_sp); end
      @(posedge clk_i); #1;
`endif
      us_ips_pul_i = 1'b1;
      @(negedge clk_i);
      checks++;
`ifdef N1_IPS_BOUNDS_CHECK_EN
      if ({us_ips_ack_o, ips_ram_re_o, ips_dsp_pul_o} !== 3'b100 || us_ips_pul_data_o !== 16'h0)
         begin failures++; $display("FAIL pull_empty got ack/re/pul=%b data=%h exp 100/0000", {us_ips_ack_o, ips_ram_re_o, ips_dsp_pul_o}, us_ips_pul_data_o); end
      @(posedge clk_i); #1 us_ips_pul_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (us_ips_err_o !== 1'b1 || agu_sp !== 12'h000)
         begin failures++; $display("FAIL pull_empty_after got err=%b sp=%h exp 1/000", us_ips_err_o, agu_sp); end
`else
      if ({us_ips_ack_o, ips_ram_re_o, ips_dsp_pul_o} !== 3'b011 || ips_ram_adr_o !== 12'h000)
         begin failures++; $display("FAIL pull_empty got ack/re/pul=%b adr=%h exp 011/000", {us_ips_ack_o, ips_ram_re_o, ips_dsp_pul_o}, ips_ram_adr_o); end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checks++;
      if (us_ips_ack_o !== 1'b1 || us_ips_pul_data_o !== 16'hBEEF)
         begin failures++; $display("FAIL pull_wrap got ack=%b data=%h exp 1/beef", us_ips_ack_o, us_ips_pul_data_o); end
      @(posedge clk_i); #1 us_ips_pul_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (agu_sp !== 12'h001 || us_ips_err_o !== 1'b0)
         begin failures++; $display("FAIL pull_wrap_after got sp=%h err=%b exp 001/0", agu_sp, us_ips_err_o); end
`endif
      @(posedge clk_i); #1;
      test_clear();
   endtask

   task automatic test_conflict();
      us_ips_psh_i = 1'b1; us_ips_pul_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({us_ips_ack_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o} !== 6'b100000)
         begin failures++; $display("FAIL conflict got=%b exp=100000", {us_ips_ack_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o}); end
      @(posedge clk_i); #1 us_ips_psh_i = 1'b0; us_ips_pul_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (us_ips_err_o !== 1'b1)
         begin failures++; $display("FAIL conflict_err got=%b exp=1", us_ips_err_o); end
      @(posedge clk_i); #1;
      test_clear();
   endtask

   task automatic test_read_ignores();
      us_ips_psh_i = 1'b1; us_ips_psh_data_i = 16'h5A5A;
      @(posedge clk_i); #1 us_ips_psh_i = 1'b0;
      us_ips_pul_i = 1'b1;
      @(posedge clk_i); #1 us_ips_psh_i = 1'b1; us_ips_rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o, ips_dsp_rst_o} !== 4'b1000 || us_ips_pul_data_o !== 16'h5A5A)
         begin failures++; $display("FAIL read_ignore got ack/we/psh/rst=%b data=%h exp 1000/5a5a", {us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o, ips_dsp_rst_o}, us_ips_pul_data_o); end
      @(posedge clk_i); #1 us_ips_psh_i = 1'b0; us_ips_rst_i = 1'b0; us_ips_pul_i = 1'b0;
   endtask

   task automatic test_async_in_read();
      int acks;
      us_ips_psh_i = 1'b1; us_ips_psh_data_i = 16'h7777;
      @(posedge clk_i); #1 us_ips_psh_i = 1'b0;
      us_ips_pul_i = 1'b1;
      @(posedge clk_i); #1 async_rst_i = 1'b1; us_ips_pul_i = 1'b0;
      #1;
      checks++;
      if ({us_ips_ack_o, us_ips_err_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o} !== 7'b0 || us_ips_pul_data_o !== 16'h0)
         begin failures++; $display("FAIL async_read got strobes=%b data=%h exp 0000000/0000", {us_ips_ack_o, us_ips_err_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o, ips_dsp_rst_o}, us_ips_pul_data_o); end
      @(posedge clk_i); #1 async_rst_i = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (us_ips_ack_o === 1'b1) acks++;
      end
      checks++;
      if (acks != 0 || agu_sp !== 12'h000)
         begin failures++; $display("FAIL async_after got acks=%0d sp=%h exp 0/000", acks, agu_sp); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_random();
      logic [15:0] q[$];
      logic [15:0] d;
      bit          err_exp;
      int          r;
      err_exp = 1'b0;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            us_ips_rst_i = 1'b1;
            @(posedge clk_i); #1;
            @(negedge clk_i);
            checks++;
            if ({ips_dsp_rst_o, us_ips_ack_o} !== 2'b11)
               begin failures++; $display("FAIL rnd_clear n=%0d got rst/ack=%b exp 11", n, {ips_dsp_rst_o, us_ips_ack_o}); end
            @(posedge clk_i); #1 us_ips_rst_i = 1'b0;
            q.delete(); err_exp = 1'b0;
         end else if (r < 8) begin
            us_ips_psh_i = 1'b1; us_ips_pul_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if ({us_ips_ack_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o} !== 5'b10000)
               begin failures++; $display("FAIL rnd_conflict n=%0d got=%b exp 10000", n, {us_ips_ack_o, ips_ram_we_o, ips_ram_re_o, ips_dsp_psh_o, ips_dsp_pul_o}); end
            @(posedge clk_i); #1 us_ips_psh_i = 1'b0; us_ips_pul_i = 1'b0;
            err_exp = 1'b1;
         end else if (q.size() == 0 || (r < 56 && q.size() < 40)) begin
            d = 16'($urandom);
            us_ips_psh_i = 1'b1; us_ips_psh_data_i = d;
            @(negedge clk_i);
            checks++;
            if ({us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o} !== 3'b111 || ips_ram_adr_o !== 12'(4095 - q.size()) || ips_ram_wdata_o !== d)
               begin failures++; $display("FAIL rnd_push n=%0d got ack/we/psh=%b adr=%h wd=%h exp 111/%h/%h", n, {us_ips_ack_o, ips_ram_we_o, ips_dsp_psh_o}, ips_ram_adr_o, ips_ram_wdata_o, 12'(4095 - q.size()), d); end
            @(posedge clk_i); #1 us_ips_psh_i = 1'b0;
            q.push_front(d);
         end else begin
            us_ips_pul_i = 1'b1;
            @(negedge clk_i);
            checks++;
            if ({ips_ram_re_o, ips_dsp_pul_o, us_ips_ack_o} !== 3'b110 || ips_ram_adr_o !== 12'(4096 - q.size()))
               begin failures++; $display("FAIL rnd_pull_issue n=%0d got re/pul/ack=%b adr=%h exp 110/%h", n, {ips_ram_re_o, ips_dsp_pul_o, us_ips_ack_o}, ips_ram_adr_o, 12'(4096 - q.size())); end
            @(posedge clk_i); #1;
            @(negedge clk_i);
            d = q.pop_front();
            checks++;
            if (us_ips_ack_o !== 1'b1 || us_ips_pul_data_o !== d)
               begin failures++; $display("FAIL rnd_pull_data n=%0d got ack=%b data=%h exp 1/%h", n, us_ips_ack_o, us_ips_pul_data_o, d); end
            @(posedge clk_i); #1 us_ips_pul_i = 1'b0;
         end
         @(negedge clk_i);
         checks++;
         if (agu_sp !== 12'(4096 - q.size()) || us_ips_err_o !== err_exp || us_ips_empty_o !== (q.size() == 0))
            begin failures++; $display("FAIL rnd_state n=%0d got sp=%h err=%b empty=%b exp %h/%b/%b", n, agu_sp, us_ips_err_o, us_ips_empty_o, 12'(4096 - q.size()), err_exp, (q.size() == 0)); end
         @(posedge clk_i); #1;
      end
   endtask

   initial begin
      test_reset();
      test_push_basic();
      test_pull_basic();
      test_bounds();
      test_conflict();
      test_read_ignores();
      test_clear();
      test_async_in_read();
      test_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
